// File: rtl/incrementer_arbiter.sv
// incrementer_arbiter: round-robin share of one incrementer among NUM_REQ requesters (request_valid/operand in, one-hot request_accept out, tagged registered response_* with valid/ready, busy)
module incrementer #(
  parameter int WIDTH = 30
) (
  input  logic [WIDTH-1:0] operand_1,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);
  assign {carry_out, result} = {1'b0, operand_1} + {{WIDTH{1'b0}}, 1'b1};
endmodule

module incrementer_arbiter #(
  parameter int WIDTH    = 30,
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       request_valid,
  input  logic [NUM_REQ*WIDTH-1:0] request_operand,
  output logic [NUM_REQ-1:0]       request_accept,
  output logic                     response_valid,
  output logic [ID_WIDTH-1:0]      response_id,
  output logic [WIDTH-1:0]         response_result,
  output logic                     response_overflow,
  input  logic                     response_ready,
  output logic                     busy
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t              state;
  logic [ID_WIDTH-1:0] ptr, win, nxt;
  logic                hit, accept, inc_carry;
  logic [WIDTH-1:0]    inc_result;
  logic [WIDTH-1:0]    ops [NUM_REQ];
  int                  j;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_ops
    assign ops[g] = request_operand[g*WIDTH +: WIDTH];
  end
  always_comb begin
    win = ptr;
    hit = 1'b0;
    j   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (request_valid[ID_WIDTH'(j)]) begin
        win = ID_WIDTH'(j);
        hit = 1'b1;
      end
    end
  end
  assign nxt            = (int'(win) + 1 == NUM_REQ) ? '0 : win + 1'b1;
  assign accept         = hit && reset && (state == EMPTY || response_ready);
  assign request_accept = accept ? NUM_REQ'(1) << win : '0;
  incrementer #(.WIDTH(WIDTH)) u_inc (
    .operand_1(ops[win]),
    .result   (inc_result),
    .carry_out(inc_carry)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state             <= EMPTY;
      ptr               <= '0;
      response_id       <= '0;
      response_result   <= '0;
      response_overflow <= 1'b0;
    end else if (accept) begin
      state             <= FULL;
      ptr               <= nxt;
      response_id       <= win;
      response_result   <= inc_result;
      response_overflow <= inc_carry;
    end else if (response_ready) begin
      state <= EMPTY;
    end
  assign response_valid = state == FULL;
  assign busy           = response_valid;
endmodule

// File: tb/tb_incrementer_arbiter.sv
// tb_incrementer_arbiter: randomized and directed checks of incrementer_arbiter against a behavioural model
module tb_incrementer_arbiter;
  localparam int N = 4;
  localparam int W = 30;
  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   request_valid = '0;
  logic [N*W-1:0] request_operand = '0;
  logic [N-1:0]   request_accept;
  logic           response_valid;
  logic [1:0]     response_id;
  logic [W-1:0]   response_result;
  logic           response_overflow;
  logic           response_ready = 1'b0;
  logic           busy;
  int nvec = 0;
  int nmis = 0;
  bit           m_full = 1'b0;
  int           m_id = 0;
  int           m_ptr = 0;
  logic [W-1:0] m_res = '0;
  bit           m_ovf = 1'b0;
  incrementer_arbiter #(.WIDTH(W), .NUM_REQ(N), .ID_WIDTH(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .request_valid    (request_valid),
    .request_operand  (request_operand),
    .request_accept   (request_accept),
    .response_valid   (response_valid),
    .response_id      (response_id),
    .response_result  (response_result),
    .response_overflow(response_overflow),
    .response_ready   (response_ready),
    .busy             (busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
    end
  endtask
  function automatic int m_win();
    for (int i = 0; i < N; i++)
      if (request_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
    return -1;
  endfunction
  function automatic logic [N-1:0] m_acc();
    if (!reset || m_win() < 0 || (m_full && !response_ready)) return '0;
    return N'(1) << m_win();
  endfunction
  function automatic logic [W-1:0] op(input int i);
    return request_operand[i*W +: W];
  endfunction
  always @(posedge clk or negedge reset)
    if (!reset) begin
      m_full <= 1'b0;
      m_id   <= 0;
      m_ptr  <= 0;
      m_res  <= '0;
      m_ovf  <= 1'b0;
    end else if (m_acc() != '0) begin
      m_full <= 1'b1;
      m_id   <= m_win();
      m_res  <= op(m_win()) + W'(1);
      m_ovf  <= op(m_win()) == '1;
      m_ptr  <= (m_win() + 1) % N;
    end else if (response_ready) begin
      m_full <= 1'b0;
    end
  always @(negedge clk) begin
    chk("model_accept", 64'(request_accept), 64'(m_acc()));
    chk("model_valid", 64'(response_valid), 64'(m_full));
    chk("model_busy", 64'(busy), 64'(m_full));
    chk("model_id", 64'(response_id), 64'(m_id));
    chk("model_result", 64'(response_result), 64'(m_res));
    chk("model_overflow", 64'(response_overflow), 64'(m_ovf));
  end
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    request_valid = '0;
    response_ready = 1'b0;
    cyc();
    reset = 1'b1;
  endtask
  task automatic set_op(input int i, input logic [W-1:0] v);
    request_operand[i*W +: W] = v;
  endtask
  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 3))
      0: return '1;
      1: return '1 - W'(1);
      2: return W'($urandom_range(0, 3));
      default: return W'($urandom);
    endcase
  endfunction
  logic [N-1:0] a = '0;
  initial begin
    repeat (2) cyc();
    #1;
    chk("rst_valid", 64'(response_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_id", 64'(response_id), 0);
    chk("rst_result", 64'(response_result), 0);
    chk("rst_overflow", 64'(response_overflow), 0);
    request_valid = 4'b0001;
    chk("rst_accept", 64'(request_accept), 0);
    reset = 1'b1;
    set_op(0, 30'h0FF);
    response_ready = 1'b1;
    #1 chk("single_accept", 64'(request_accept), 64'b0001);
    cyc();
    request_valid = '0;
    #1;
    chk("single_valid", 64'(response_valid), 1);
    chk("single_id", 64'(response_id), 0);
    chk("single_result", 64'(response_result), 64'h100);
    chk("single_overflow", 64'(response_overflow), 0);
    cyc();
    #1 chk("single_drain", 64'(response_valid), 0);
    do_reset();
    request_valid = 4'b1111;
    for (int i = 0; i < N; i++) set_op(i, W'(i * 16));
    response_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (k > 0) begin
        chk("rr_valid", 64'(response_valid), 1);
        chk("rr_id", 64'(response_id), 64'((k - 1) % 4));
        chk("rr_result", 64'(response_result), 64'(((k - 1) % 4) * 16 + 1));
      end
      chk("rr_accept", 64'(request_accept), 64'(1) << (k % 4));
      cyc();
    end
    request_valid = '0;
    #1 chk("rr_last_result", 64'(response_result), 1);
    do_reset();
    request_valid = 4'b0100;
    set_op(2, 30'h5);
    set_op(1, 30'h7);
    response_ready = 1'b1;
    #1 chk("bp_accept2", 64'(request_accept), 64'b0100);
    cyc();
    request_valid = 4'b0010;
    response_ready = 1'b0;
    repeat (3) begin
      #1;
      chk("bp_hold_result", 64'(response_result), 6);
      chk("bp_hold_id", 64'(response_id), 2);
      chk("bp_hold_valid", 64'(response_valid), 1);
      chk("bp_stall_accept", 64'(request_accept), 0);
      cyc();
    end
    response_ready = 1'b1;
    #1 chk("bp_release_accept", 64'(request_accept), 64'b0010);
    cyc();
    request_valid = '0;
    #1;
    chk("bp_next_id", 64'(response_id), 1);
    chk("bp_next_result", 64'(response_result), 8);
    cyc();
    request_valid = 4'b0001;
    set_op(0, '1);
    #1 chk("wrap_accept", 64'(request_accept), 64'b0001);
    cyc();
    request_valid = 4'b0010;
    set_op(1, 30'h3FFF_FFFE);
    #1;
    chk("wrap_result", 64'(response_result), 0);
    chk("wrap_overflow", 64'(response_overflow), 1);
    chk("wrap_accept1", 64'(request_accept), 64'b0010);
    cyc();
    request_valid = '0;
    #1;
    chk("near_wrap_result", 64'(response_result), 64'h3FFF_FFFF);
    chk("near_wrap_overflow", 64'(response_overflow), 0);
    cyc();
    request_valid = 4'b0001;
    set_op(0, 30'h9);
    set_op(1, 30'h7);
    cyc();
    request_valid = 4'b1010;
    response_ready = 1'b0;
    #1 chk("mid_full", 64'(response_result), 64'hA);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(response_valid), 0);
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_accept", 64'(request_accept), 0);
    chk("mid_rst_result", 64'(response_result), 0);
    cyc();
    reset = 1'b1;
    response_ready = 1'b1;
    #1 chk("post_rst_accept", 64'(request_accept), 64'b0010);
    cyc();
    request_valid = '0;
    #1 chk("post_rst_result", 64'(response_result), 8);
    do_reset();
    response_ready = 1'b1;
    request_valid = 4'b1000;
    set_op(3, '0);
    #1 chk("sparse_accept3", 64'(request_accept), 64'b1000);
    cyc();
    request_valid = 4'b0100;
    set_op(2, 30'h5);
    #1;
    chk("sparse_id3", 64'(response_id), 3);
    chk("sparse_accept2", 64'(request_accept), 64'b0100);
    cyc();
    request_valid = 4'b0101;
    set_op(0, 30'h9);
    #1;
    chk("sparse_result2", 64'(response_result), 6);
    chk("sparse_ptr3_accept", 64'(request_accept), 64'b0001);
    cyc();
    request_valid = '0;
    cyc();
    a = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++)
        if (a[i] || !request_valid[i]) begin
          request_valid[i] = 1'($urandom_range(0, 1));
          set_op(i, rnd_op());
        end else if ($urandom_range(0, 15) == 0) begin
          request_valid[i] = 1'b0;
        end
      response_ready = $urandom_range(0, 3) != 0;
      a = m_acc();
      cyc();
    end
    request_valid = '0;
    response_ready = 1'b1;
    repeat (3) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
